// File: rtl/game_pkg.sv
// game_pkg: shared screen geometry, lane slot type and LFSR helper for all lanes
package game_pkg;
  localparam int SCREEN_WIDTH = 640;
  localparam int SCREEN_HEIGHT = 480;
  localparam int PLAYER_SZ = 32;
  localparam logic [7:0] LFSR8_TAPS = 8'hB8;
  typedef struct packed {
    logic act;
    logic [10:0] t;
  } slot_t;
  function automatic logic [7:0] lfsr8_next(input logic [7:0] x);
    return {x[6:0], ^(x & LFSR8_TAPS)};
  endfunction
endpackage

// File: rtl/lane_lfsr.sv
// lane_lfsr: 8-bit spawn-randomness LFSR that shifts once per accepted step
module lane_lfsr
  import game_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       step,
  output logic [7:0] lfsr
);
  localparam logic [7:0] INIT = (SEED == 8'h00) ? 8'h01 : SEED;
  // an all-zero state would lock up, so a zero seed starts from 1
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) lfsr <= INIT;
    else if (step) lfsr <= lfsr8_next(lfsr);
endmodule

// File: rtl/lane_traffic.sv
// lane_traffic: car slots of one road lane, their pixel mask and sticky player collision
module lane_traffic
  import game_pkg::*;
#(
  parameter logic [9:0] LANE_Y = 10'd160,
  parameter int LANE_H = 32,
  parameter int CAR_W = 48,
  parameter int NUM_CARS = 4,
  parameter int DIR = 0,
  parameter int MOVE_AMT = 2,
  parameter int GAP_STEPS = 40,
  parameter logic [7:0] SEED = 8'hA4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                move_followers,
  input  logic                enable,
  input  logic [9:0]          px,
  input  logic [9:0]          py,
  input  logic [9:0]          player_x,
  input  logic [9:0]          player_y,
  input  logic                clear_hit,
  output logic                car_pixel,
  output logic                hit,
  output logic [NUM_CARS-1:0] active
);
  localparam int CD_W = $clog2(GAP_STEPS + 2);
  localparam logic [10:0] SW = 11'(SCREEN_WIDTH);
  localparam logic [10:0] SH = 11'(SCREEN_HEIGHT);
  localparam logic [10:0] T_END = 11'(SCREEN_WIDTH + CAR_W);
  localparam logic [10:0] CW = 11'(CAR_W);
  localparam logic [10:0] MA = 11'(MOVE_AMT);
  localparam logic [10:0] PS = 11'(PLAYER_SZ);
  localparam logic [10:0] LY = 11'(LANE_Y);
  localparam logic [10:0] LY_END = 11'(int'(LANE_Y) + LANE_H);
  slot_t [NUM_CARS-1:0] slot, slot_nxt;
  logic [NUM_CARS-1:0] free_v, first_free, spawn_oh, cov, ovl;
  logic [CD_W-1:0] cooldown;
  logic [7:0] lfsr;
  logic [10:0] x11, y11, plx, ply;
  logic step, spawn, in_lane, on_screen, p_lane;
  assign step = move_followers & enable;
  assign x11 = {1'b0, px};
  assign y11 = {1'b0, py};
  assign plx = {1'b0, player_x};
  assign ply = {1'b0, player_y};
  assign in_lane = (y11 >= LY) && (y11 < LY_END);
  assign on_screen = (x11 < SW) && (y11 < SH);
  assign p_lane = (LY < ply + PS) && (ply < LY_END);
  assign free_v = ~active;
  assign first_free = free_v & (~free_v + NUM_CARS'(1));
  assign spawn = step && (cooldown == '0) && (lfsr[1:0] == 2'b00) && (|free_v);
  assign spawn_oh = spawn ? first_free : '0;
  lane_lfsr #(.SEED(SEED)) u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .step (step),
    .lfsr (lfsr)
  );
  for (genvar i = 0; i < NUM_CARS; i++) begin : g_slot
    logic [10:0] t_adv;
    logic h_cov, h_ovl;
    assign active[i] = slot[i].act;
    assign t_adv = slot[i].t + MA;
    assign slot_nxt[i] = spawn_oh[i] ? {1'b1, MA} :
                         (slot[i].act && t_adv < T_END) ? {1'b1, t_adv} :
                         slot[i].act ? '0 : slot[i];
    if (DIR == 0) begin : g_ltr
      assign h_cov = (x11 + CW >= slot[i].t) && (x11 < slot[i].t);
      assign h_ovl = (slot[i].t < plx + PS + CW) && (plx < slot[i].t);
    end else begin : g_rtl
      assign h_cov = (x11 + slot[i].t >= SW) && (x11 + slot[i].t < T_END);
      assign h_ovl = (plx + slot[i].t + PS > SW) && (plx + slot[i].t < T_END);
    end
    assign cov[i] = slot[i].act & h_cov;
    assign ovl[i] = slot[i].act & p_lane & h_ovl;
  end
  // slots and spawn cooldown advance only on accepted steps
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      slot <= '0;
      cooldown <= '0;
    end else if (step) begin
      slot <= slot_nxt;
      cooldown <= spawn ? CD_W'(GAP_STEPS) : (cooldown != '0) ? cooldown - CD_W'(1) : cooldown;
    end
  // registered pixel mask and sticky hit where a new overlap beats a clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      car_pixel <= 1'b0;
      hit <= 1'b0;
    end else begin
      car_pixel <= on_screen & in_lane & (|cov);
      hit <= (hit & ~clear_hit) | (|ovl);
    end
endmodule
